imem_loader: RTL and testbench

Writer side of the byte-addressed instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and writes each payload byte, one per cycle, into consecutive instruction-memory byte addresses, least-significant byte of each word first. Holds the CPU in reset until a complete image has been written. Sits between the host/debug byte link and the write port of the instruction memory array.

---
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 tb/tb_imem_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory writer: length-prefixed byte stream to consecutive byte addresses, holding the CPU in reset until the image is complete.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 8,
    parameter int                         MEM_BITS      = 12,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     err,
    output logic [MEM_BITS:0]        bytes_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_LEN = 32'd1 << MEM_BITS;

    state_t                   r_state, w_state;
    logic                     r_in_ready, w_in_ready;
    logic                     r_wr_en, w_wr_en;
    logic [ADDRESS_WIDTH-1:0] r_wr_addr, w_wr_addr;
    logic [DATA_WIDTH-1:0]    r_wr_data, w_wr_data;
    logic                     r_cpu_hold, w_cpu_hold;
    logic                     r_done, w_done;
    logic                     r_err, w_err;
    logic [MEM_BITS:0]        r_bytes, w_bytes;
    logic [31:0]              r_len, w_len;
    logic [1:0]               r_hdr, w_hdr;
    logic                     w_xfer;
    logic [31:0]              w_len_full;
    logic [MEM_BITS:0]        w_idx_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]               r_sum, w_sum;
`endif

    assign w_xfer     = in_valid && r_in_ready;
    // Little-endian header: each new byte enters at the top, so the first byte ends up in [7:0].
    assign w_len_full = {in_data[7:0], r_len[31:8]};
    assign w_idx_next = r_bytes + 1'b1;

    always_comb begin
        w_state   = r_state;
        w_wr_en   = 1'b0;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_bytes   = r_bytes;
        w_len     = r_len;
        w_hdr     = r_hdr;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_sum     = r_sum;
`endif
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    w_state = S_LEN;
                    w_bytes = '0;
                    w_len   = '0;
                    w_hdr   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_sum   = '0;
`endif
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    w_len = w_len_full;
                    w_hdr = r_hdr + 2'd1;
                    if (r_hdr == 2'd3) begin
                        if (w_len_full == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            w_state = S_CHK;
`else
                            w_state = S_DONE;
`endif
                        end else if (w_len_full > MAX_LEN) begin
                            w_state = S_ERR;
                        end else begin
                            w_state = S_LOAD;
                        end
                    end
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = BASE_ADDR + ADDRESS_WIDTH'(r_bytes);
                    w_wr_data = in_data;
                    w_bytes   = w_idx_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_sum     = r_sum + in_data[7:0];
`endif
                    if (32'(w_idx_next) == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_state = S_CHK;
`else
                        w_state = S_DONE;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_xfer) begin
                    w_state = (in_data[7:0] == r_sum) ? S_DONE : S_ERR;
                end
            end
`endif
            default: w_state = S_IDLE;
        endcase

        // Status outputs are a pure function of the next state, so done lands with the final write.
        w_done     = (w_state == S_DONE);
        w_err      = (w_state == S_ERR);
        w_cpu_hold = (w_state != S_DONE);
        w_in_ready = (w_state == S_LEN) || (w_state == S_LOAD)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (w_state == S_CHK)
`endif
                     ;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_bytes    <= '0;
            r_len      <= '0;
            r_hdr      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_in_ready <= w_in_ready;
            r_wr_en    <= w_wr_en;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            r_cpu_hold <= w_cpu_hold;
            r_done     <= w_done;
            r_err      <= w_err;
            r_bytes    <= w_bytes;
            r_len      <= w_len;
            r_hdr      <= w_hdr;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum      <= w_sum;
`endif
        end
    end

    assign in_ready     = r_in_ready;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign err          = r_err;
    assign bytes_loaded = r_bytes;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image load, empty image, oversize header, stalled stream, reset mid-load.
// Optional checksum scenarios follow IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [12:0] bytes_loaded;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int w0;

    imem_loader #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(8), .MEM_BITS(12), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .err(err), .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en) n_wr++;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfer one byte; checks the write that appears one cycle later (or its absence).
    task automatic xfer(input logic [7:0] b, input bit expw, input int idx);
        int k = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        if (expw) begin
            chk("wr_en", wr_en, 1);
            chk("wr_addr", wr_addr, idx);
            chk("wr_data", wr_data, b);
            chk("bytes_loaded", bytes_loaded, idx + 1);
        end else begin
            chk("no_wr", wr_en, 0);
        end
    endtask

    task automatic idle(input bit v, input bit st);
        in_valid = v;
        start    = st;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("idle_no_wr", wr_en, 0);
    endtask

    task automatic do_start();
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_ready", in_ready, 1);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
        chk("start_hold", cpu_hold, 1);
        chk("start_bytes", bytes_loaded, 0);
    endtask

    task automatic header(input logic [31:0] len);
        xfer(len[7:0], 0, 0);
        xfer(len[15:8], 0, 0);
        xfer(len[23:16], 0, 0);
        xfer(len[31:24], 0, 0);
    endtask

    // Completes a load: sends the checksum byte when that feature is built, then checks DONE outputs.
    task automatic finish_ok(input logic [7:0] csum, input int n);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("pre_chk_done", done, 0);
        xfer(csum, 0, 0);
`endif
        in_valid = 1'b0;
        chk("done", done, 1);
        chk("done_hold", cpu_hold, 0);
        chk("done_ready", in_ready, 0);
        chk("done_err", err, 0);
        chk("done_bytes", bytes_loaded, n);
    endtask

    task automatic run_image();
        logic [7:0] img [8];
        img = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hF0, 8'h0F};
        w0 = n_wr;
        do_start();
        header(32'd8);
        for (int i = 0; i < 8; i++) xfer(img[i], 1, i);
        finish_ok(8'hFF, 8);
        idle(0, 0);
        chk("img_wr_count", n_wr - w0, 8);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_bytes", bytes_loaded, 0);
        rst = 1'b1;

        // in_valid with in_ready low is not consumed
        w0 = n_wr;
        idle(1, 0);
        idle(1, 0);
        chk("idle_ready", in_ready, 0);
        chk("idle_wr_count", n_wr - w0, 0);

        // 1: eight-byte image
        run_image();

        // 2: empty image, start from DONE
        w0 = n_wr;
        do_start();
        header(32'd0);
        finish_ok(8'h00, 0);
        chk("empty_wr_count", n_wr - w0, 0);

        // 3: oversize header (4097)
        w0 = n_wr;
        do_start();
        header(32'h0000_1001);
        in_valid = 1'b0;
        chk("err", err, 1);
        chk("err_hold", cpu_hold, 1);
        chk("err_ready", in_ready, 0);
        chk("err_done", done, 0);
        idle(1, 0);
        idle(0, 0);
        chk("err_stays", err, 1);
        chk("err_wr_count", n_wr - w0, 0);
        do_start();

        // 4: L=4 with stalled stream, start pulse in LOAD ignored
        w0 = n_wr;
        header(32'd4);
        xfer(8'hAA, 1, 0);
        idle(0, 1);
        idle(0, 0);
        chk("stall_bytes", bytes_loaded, 1);
        xfer(8'hBB, 1, 1);
        idle(0, 0);
        xfer(8'hCC, 1, 2);
        xfer(8'hDD, 1, 3);
        finish_ok(8'h0E, 4);
        idle(0, 0);
        chk("stall_wr_count", n_wr - w0, 4);

        // 5: reset after three payload bytes, then full reload
        do_start();
        header(32'd8);
        xfer(8'h11, 1, 0);
        xfer(8'h22, 1, 1);
        xfer(8'h33, 1, 2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_addr", wr_addr, 0);
        chk("mid_rst_data", wr_data, 0);
        chk("mid_rst_hold", cpu_hold, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_bytes", bytes_loaded, 0);
        rst = 1'b1;
        run_image();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum good then bad
        do_start();
        header(32'd2);
        xfer(8'hFF, 1, 0);
        xfer(8'h02, 1, 1);
        finish_ok(8'h01, 2);
        do_start();
        header(32'd2);
        xfer(8'hFF, 1, 0);
        xfer(8'h02, 1, 1);
        xfer(8'h00, 0, 0);
        in_valid = 1'b0;
        chk("csum_err", err, 1);
        chk("csum_err_hold", cpu_hold, 1);
        chk("csum_err_done", done, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
